// File: rtl/row_predec_pkg.sv
// Shared definitions for the row pre-decoder sequencer.
//   state_t    : sequencer phases IDLE / ACTIVE / PRECHARGE
//   ADDR_W_MAX : largest supported row-address width
//   CYC_MAX    : largest phase length the 4-bit phase counter can time
package row_predec_pkg;

  localparam int unsigned ADDR_W_MAX = 6;
  localparam int unsigned CYC_MAX    = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    PRECHARGE = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec_n.sv
// Combinational one-hot-low decoder.
//   i_addr  : ADDR_W-bit row address
//   o_dec_n : 2**ADDR_W outputs, bit i_addr low, all others high
module onehot_dec_n #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]        i_addr,
  output logic [(1<<ADDR_W)-1:0]   o_dec_n
);

  always_comb begin
    o_dec_n         = '1;
    o_dec_n[i_addr] = 1'b0;
  end

endmodule

// File: rtl/row_predec_seq.sv
// Row pre-decoder sequencer: accepts a row address, drives one active-low
// wordline for PULSE_CYC cycles, precharges for PRE_CYC cycles, then
// pulses done and returns to IDLE.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/req_ready, req_addr : request handshake and row address
//   addr_par          : odd parity over req_addr (only with ROW_PREDEC_PARITY_EN)
//   wl_n              : registered one-hot-low wordline select
//   busy              : access in progress (state not IDLE)
//   done              : one-cycle completion pulse on first IDLE cycle
//   err               : one-cycle parity-error pulse (tied 0 without the macro)
// Build option: define ROW_PREDEC_PARITY_EN to enable address parity checking.
module row_predec_seq
  import row_predec_pkg::*;
#(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned PRE_CYC   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
`ifdef ROW_PREDEC_PARITY_EN
  input  logic                     addr_par,
`endif
  output logic                     req_ready,
  output logic [(1<<ADDR_W)-1:0]   wl_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  if (ADDR_W < 1 || ADDR_W > ADDR_W_MAX ||
      PULSE_CYC < 1 || PULSE_CYC > CYC_MAX ||
      PRE_CYC < 1 || PRE_CYC > CYC_MAX) begin : g_bad_cfg
    $error("row_predec_seq: parameter out of range");
  end

  // Phase counter is loaded with length-1 and the phase ends when it reads 0.
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] PRE_LD   = 4'(PRE_CYC - 1);

  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic [(1<<ADDR_W)-1:0]    r_wl_n;
  logic                      r_ready;
  logic                      r_done;
  logic [(1<<ADDR_W)-1:0]    w_dec_n;
  logic                      w_accept;
  logic                      w_par_ok;

  onehot_dec_n #(.ADDR_W(ADDR_W)) u_dec (
    .i_addr  (req_addr),
    .o_dec_n (w_dec_n)
  );

  assign w_accept = req_valid && r_ready;

`ifdef ROW_PREDEC_PARITY_EN
  logic r_err;
  assign w_par_ok = ^{req_addr, addr_par};
  assign err      = r_err;
`else
  assign w_par_ok = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wl_n  <= '1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
`ifdef ROW_PREDEC_PARITY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef ROW_PREDEC_PARITY_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_par_ok) begin
              r_state <= ACTIVE;
              r_cnt   <= PULSE_LD;
              r_wl_n  <= w_dec_n;
            end else begin
              // Bad address: skip the wordline pulse, still precharge and report done.
              r_state <= PRECHARGE;
              r_cnt   <= PRE_LD;
`ifdef ROW_PREDEC_PARITY_EN
              r_err   <= 1'b1;
`endif
            end
          end
        end
        ACTIVE: begin
          if (r_cnt == '0) begin
            r_state <= PRECHARGE;
            r_cnt   <= PRE_LD;
            r_wl_n  <= '1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        PRECHARGE: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_wl_n  <= '1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign wl_n      = r_wl_n;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_row_predec_seq.sv
module tb_row_predec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-configuration DUT (ADDR_W=2, PULSE_CYC=2, PRE_CYC=1)
  logic        valid = 1'b0;
  logic [1:0]  addr = '0;
  logic        ready, busy, done, err;
  logic [3:0]  wl_n;

  // Wide DUT (ADDR_W=6)
  logic        v6 = 1'b0;
  logic [5:0]  a6 = '0;
  logic        ready6, busy6, done6, err6;
  logic [63:0] wl6;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROW_PREDEC_PARITY_EN
  // Odd parity: {addr,par} must have odd weight; par_flip forces an error.
  logic par_flip = 1'b0;
  logic par, par6;
  assign par  = ~(^addr) ^ par_flip;
  assign par6 = ~(^a6);
`endif

  row_predec_seq #(.ADDR_W(2), .PULSE_CYC(2), .PRE_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (valid),
    .req_addr  (addr),
`ifdef ROW_PREDEC_PARITY_EN
    .addr_par  (par),
`endif
    .req_ready (ready),
    .wl_n      (wl_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  row_predec_seq #(.ADDR_W(6), .PULSE_CYC(2), .PRE_CYC(1)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v6),
    .req_addr  (a6),
`ifdef ROW_PREDEC_PARITY_EN
    .addr_par  (par6),
`endif
    .req_ready (ready6),
    .wl_n      (wl6),
    .busy      (busy6),
    .done      (done6),
    .err       (err6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL rst_wl_n got=%b exp=%b", wl_n, 4'b1111); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
    n_checks++; if (wl6 !== {64{1'b1}}) begin n_fail++; $display("FAIL rst_wl6 got=%h", wl6); end
    n_checks++; if (ready6 !== 1'b0) begin n_fail++; $display("FAIL rst_ready6 got=%b exp=0", ready6); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready got=%b exp=1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_rel_busy got=%b exp=0", busy); end
    n_checks++; if (ready6 !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready6 got=%b exp=1", ready6); end
  endtask

  // addr=2: low on cycles 1-2, precharge cycle 3, done cycle 4; request traffic
  // during the access must be ignored.
  task automatic test_single();
    valid = 1'b1; addr = 2'd2;
    tick(); // cycle 1
    n_checks++; if (wl_n !== 4'b1011) begin n_fail++; $display("FAIL single_c1_wl got=%b exp=%b", wl_n, 4'b1011); end
    n_checks++; if (busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL single_c1_hs busy=%b ready=%b exp busy=1 ready=0", busy, ready); end
    addr = 2'd1; // still valid, must be ignored
    tick(); // cycle 2
    n_checks++; if (wl_n !== 4'b1011) begin n_fail++; $display("FAIL single_c2_wl got=%b exp=%b", wl_n, 4'b1011); end
    tick(); // cycle 3
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL single_c3_wl got=%b exp=%b", wl_n, 4'b1111); end
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_c3_st done=%b busy=%b exp done=0 busy=1", done, busy); end
    valid = 1'b0;
    tick(); // cycle 4
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_c4_done got=%b exp=1", done); end
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c4_hs ready=%b busy=%b exp ready=1 busy=0", ready, busy); end
    tick(); // cycle 5
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_c5_done got=%b exp=0", done); end
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL single_c5_wl got=%b exp=%b", wl_n, 4'b1111); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_wl [8] = '{4'b1110, 4'b1110, 4'b1111, 4'b1111,
                               4'b0111, 4'b0111, 4'b1111, 4'b1111};
    logic       exp_dn [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    valid = 1'b1; addr = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (wl_n !== exp_wl[i]) begin n_fail++; $display("FAIL b2b_wl[%0d] got=%b exp=%b", i, wl_n, exp_wl[i]); end
      n_checks++; if (done !== exp_dn[i]) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done, exp_dn[i]); end
      n_checks++; if ($countones(~wl_n) > 1) begin n_fail++; $display("FAIL b2b_onehot[%0d] got=%b exp=at most one low", i, wl_n); end
      if (i == 1) addr = 2'd3;
      if (i == 4) valid = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    valid = 1'b1; addr = 2'd1;
    tick();
    n_checks++; if (wl_n !== 4'b1101) begin n_fail++; $display("FAIL mrst_c1_wl got=%b exp=%b", wl_n, 4'b1101); end
    valid = 1'b0;
    tick();
    n_checks++; if (wl_n !== 4'b1101) begin n_fail++; $display("FAIL mrst_c2_wl got=%b exp=%b", wl_n, 4'b1101); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL mrst_async_wl got=%b exp=%b", wl_n, 4'b1111); end
    n_checks++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL mrst_async_hs busy=%b ready=%b exp 0 0", busy, ready); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_hold_done got=%b exp=0", done); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mrst_rel_ready got=%b exp=1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_rel_done got=%b exp=0", done); end
    tick();
    n_checks++; if (done !== 1'b0 || wl_n !== 4'b1111) begin n_fail++; $display("FAIL mrst_after done=%b wl_n=%b exp done=0 wl_n=1111", done, wl_n); end
  endtask

`ifdef ROW_PREDEC_PARITY_EN
  task automatic test_parity();
    valid = 1'b1; addr = 2'd1; par_flip = 1'b1;
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL par_err got=%b exp=1", err); end
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL par_wl got=%b exp=%b", wl_n, 4'b1111); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL par_busy got=%b exp=1", busy); end
    valid = 1'b0; par_flip = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL par_err_clr got=%b exp=0", err); end
    n_checks++; if (done !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL par_done done=%b ready=%b exp 1 1", done, ready); end
    n_checks++; if (wl_n !== 4'b1111) begin n_fail++; $display("FAIL par_wl_end got=%b exp=%b", wl_n, 4'b1111); end
  endtask
`endif

  task automatic test_width_sweep();
    logic [63:0] exp;
    for (int a = 0; a < 64; a++) begin
      exp = ~(64'd1 << a);
      v6 = 1'b1; a6 = 6'(a);
      tick();
      n_checks++; if (wl6 !== exp) begin n_fail++; $display("FAIL sweep_c1[%0d] got=%h exp=%h", a, wl6, exp); end
      v6 = 1'b0;
      tick();
      n_checks++; if (wl6 !== exp) begin n_fail++; $display("FAIL sweep_c2[%0d] got=%h exp=%h", a, wl6, exp); end
      tick();
      n_checks++; if (wl6 !== {64{1'b1}}) begin n_fail++; $display("FAIL sweep_c3[%0d] got=%h exp=all ones", a, wl6); end
      tick();
      n_checks++; if (done6 !== 1'b1 || ready6 !== 1'b1) begin n_fail++; $display("FAIL sweep_done[%0d] done=%b ready=%b exp 1 1", a, done6, ready6); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_reset();
`ifdef ROW_PREDEC_PARITY_EN
    test_parity();
`endif
    test_width_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
